// File: rtl/alu_iter_if.sv
// Request/response bundle between the control unit and the iterative ALU.
interface alu_iter_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [15:0] remainder;
    logic        err;

    modport master (
        output start, a, b, opcode,
        input  busy, done, result, remainder, err
    );

    modport slave (
        input  start, a, b, opcode,
        output busy, done, result, remainder, err
    );
endinterface

// File: rtl/alu_iter.sv
// Handshake-driven multi-cycle ALU: single-cycle add/sub/logic/rotate, 16-step MUL and DIV.
// Optional rotate support (opcodes 9/11) is enabled by defining ALU_ITER_ROTATE_EN.
module alu_iter (
    input  logic       clk,
    input  logic       rst_n,
    alu_iter_if.slave  bus
);
    localparam int unsigned OP_W   = 16;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
`ifdef ALU_ITER_ROTATE_EN
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd11;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic [OP_W-1:0]    rem_q, rem_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [RES_W-1:0]   op_res;
    logic               op_err;
    logic [RES_W-1:0]   add_ext;
    logic [RES_W-1:0]   sub_ext;
    logic [OP_W:0]      mul_sum;
    logic [RES_W-1:0]   mul_nxt;
    logic [OP_W:0]      div_sh;
    logic [OP_W+1:0]    div_diff;
    logic [RES_W-1:0]   div_nxt;
`ifdef ALU_ITER_ROTATE_EN
    logic [RES_W-1:0]   rot_l;
    logic [RES_W-1:0]   rot_r;
`endif

    // Single-cycle datapath, evaluated straight from the request inputs.
    always_comb begin
        add_ext = {{16{bus.a[15]}}, bus.a} + {{16{bus.b[15]}}, bus.b};
        sub_ext = {{16{bus.a[15]}}, bus.a} - {{16{bus.b[15]}}, bus.b};
`ifdef ALU_ITER_ROTATE_EN
        rot_l   = {bus.a, bus.a} << bus.b[3:0];
        rot_r   = {bus.a, bus.a} >> bus.b[3:0];
`endif
        op_res  = '0;
        op_err  = 1'b0;
        case (bus.opcode)
            OP_ADD:  op_res = add_ext;
            OP_SUB:  op_res = sub_ext;
            OP_AND:  op_res = {16'h0, bus.a & bus.b};
            OP_OR:   op_res = {16'h0, bus.a | bus.b};
`ifdef ALU_ITER_ROTATE_EN
            OP_ROL:  op_res = {16'h0, rot_l[31:16]};
            OP_ROR:  op_res = {16'h0, rot_r[15:0]};
`endif
            default: op_err = 1'b1;
        endcase
    end

    // One shift-add step: acc holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, a_q} : 17'd0);
        mul_nxt = {mul_sum, acc_q[15:1]};
    end

    // One restoring-division step: acc holds {partial remainder, dividend/quotient}.
    always_comb begin
        div_sh   = {acc_q[31:16], acc_q[15]};
        div_diff = {1'b0, div_sh} - {2'b00, b_q};
        if (!div_diff[OP_W+1])
            div_nxt = {div_diff[15:0], acc_q[14:0], 1'b1};
        else
            div_nxt = {div_sh[15:0], acc_q[14:0], 1'b0};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rem_d    = rem_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    if (bus.opcode == OP_MUL) begin
                        acc_d   = {16'h0, bus.b};
                        cnt_d   = CNT_W'(15);
                        state_d = S_MUL;
                    end else if (bus.opcode == OP_DIV && bus.b != 16'h0) begin
                        acc_d   = {16'h0, bus.a};
                        cnt_d   = CNT_W'(15);
                        state_d = S_DIV;
                    end else if (bus.opcode == OP_DIV) begin
                        result_d = 32'h0000_FFFF;
                        rem_d    = bus.a;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        result_d = op_res;
                        rem_d    = '0;
                        err_d    = op_err;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                if (cnt_q == '0) begin
                    result_d = mul_nxt;
                    rem_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                acc_d = div_nxt;
                if (cnt_q == '0) begin
                    result_d = {16'h0, div_nxt[15:0]};
                    rem_d    = div_nxt[31:16];
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.remainder = rem_q;
    assign bus.err       = err_q;
endmodule
